// File: rtl/bcd_serial_alu.sv
// Multi-digit BCD add/subtract sequencer: one shared decimal digit adder,
// one digit per clock (LSD first), carry rippled through a register.
module bcd_serial_alu #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic            carry, carry_n;
  logic [W-1:0]    a_r, a_n, b_r, b_n;
  logic            sub_r, sub_n;
  logic [W-1:0]    result_n;
  logic            cout_n, err_n, busy_n, done_n;

  logic [3:0]      a_dig, b_dig, bd, digit;
  logic [4:0]      sum;
  logic            carry_o;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Shared decimal digit adder; B is nines-complemented for subtraction.
  assign a_dig   = a_r[4*idx +: 4];
  assign b_dig   = b_r[4*idx +: 4];
  assign bd      = sub_r ? (4'd9 - b_dig) : b_dig;
  assign sum     = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry};
  assign carry_o = (sum >= 5'd10);
  assign digit   = carry_o ? 4'(sum - 5'd10) : sum[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      carry  <= carry_n;
      a_r    <= a_n;
      b_r    <= b_n;
      sub_r  <= sub_n;
      result <= result_n;
      cout   <= cout_n;
      err    <= err_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    carry_n  = carry;
    a_n      = a_r;
    b_n      = b_r;
    sub_n    = sub_r;
    result_n = result;
    cout_n   = cout;
    err_n    = err;
    case (state)
      IDLE: begin
        if (start) begin
          result_n = '0;
          cout_n   = 1'b0;
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            a_n     = a;
            b_n     = b;
            sub_n   = sub;
            idx_n   = '0;
            carry_n = sub;
            err_n   = 1'b0;
            state_n = RUN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        result_n[4*idx +: 4] = digit;
        carry_n              = carry_o;
        if (idx == IW'(DIGITS - 1)) begin
          cout_n  = carry_o;
          state_n = DONE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // busy/done are registered decodes of the upcoming state.
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Multi-digit BCD add/subtract sequencer that shares one decimal digit-adder stage across all digit positions. It processes one digit per clock, least-significant first, and ripples the decimal carry through a register between digits. Subtraction uses ten's complement: each B digit is nines-complemented and the initial carry-in is set to 1. The block sits between the keypad/operand registers and the display formatter, and reports completion with a start/done handshake.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B (ten's complement); sampled with start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]; sampled with start.
- b  input  4*DIGITS  operand B, packed BCD; sampled with start.
- result  output  4*DIGITS  packed BCD result; holds until the next accepted start.
- cout  output  1  final decimal carry. Add: overflow past DIGITS digits. Sub: 1 = no borrow (A≥B).
- err  output  1  operand contained a digit >9; holds until the next accepted start.
- busy  output  1  high in LOAD-accepted RUN and DONE states.
- done  output  1  one-cycle pulse when result/cout/err are valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, all digits of a and b ≤9:
  - latch a, b, sub into internal registers;
  - idx←0, carry←sub, result←0;
  - err←0, cout←0;
  - go to RUN.
- IDLE, start=1, any digit >9:
  - result←0, cout←0, err←1;
  - go to DONE directly; no RUN cycles.
- IDLE, start=0: remain in IDLE; outputs hold.
- RUN, each cycle, for digit i=idx:
  - bd = sub ? (9 − b_i) : b_i;
  - s = a_i + bd + carry, 5-bit, range 0..19;
  - if s≥10: digit=s−10 and carry←1; else digit=s and carry←0;
  - result[4i+3:4i]←digit.
  - If idx=DIGITS−1: cout←new carry and go to DONE. Otherwise idx←idx+1.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing: a start asserted then is lost.
- Latched operands isolate the computation from input changes after acceptance.
- Internal digit-index counter width: clog2(DIGITS), minimum 1.

## Timing
- Reset (async assert, state takes effect immediately):
  - state=IDLE;
  - result=0, cout=0, err=0;
  - busy=0, done=0;
  - idx=0, carry=0.
- Reset asserted mid-RUN aborts the operation. No done pulse is issued; outputs go to their reset values.
- Valid operation, start sampled at edge E:
  - RUN occupies the cycles after edges E … E+DIGITS−1;
  - done=1 during the cycle after edge E+DIGITS;
  - latency = DIGITS+1 cycles from the start edge to the done cycle.
- Invalid operation: done=1 in the cycle after edge E (latency 1).
- busy=1 from the cycle after the accepted edge through the done cycle inclusive. busy=0 in IDLE.
- Back-to-back use: a start held high in IDLE is accepted on the edge that ends the done cycle's successor IDLE cycle. Minimum issue interval is DIGITS+2 cycles.
- result digits update progressively during RUN. They are valid only when done=1 and thereafter, until the next accepted start clears them.
- done, busy, and err are registered (no combinational path from inputs).

## Test plan
- Add, DIGITS=4: a=0x1234, b=0x5678, sub=0 → done 5 cycles after the start edge; result=0x6912, cout=0, err=0.
- Add with overflow: a=0x9999, b=0x0001, sub=0 → result=0x0000, cout=1. Also a=0x0000, b=0x0000 → result=0x0000, cout=0.
- Subtract:
  - a=0x5000, b=0x1234, sub=1 → result=0x3766, cout=1;
  - a=0x1234, b=0x5000, sub=1 → result=0x6234, cout=0;
  - a=b=0x0042, sub=1 → result=0x0000, cout=1.
- Invalid digit: a=0x12A4, b=0x0001 → done 1 cycle after the start edge; err=1, result=0x0000, cout=0. A following valid start clears err.
- Busy protocol: pulse start again at cycle 2 of RUN with different operands → ignored; first result unchanged; exactly one done pulse. A start held high continuously → operations issue every 6 cycles.
- Reset mid-op: assert rst during the third RUN cycle → outputs immediately 0, no done. After release, a new 0x0001+0x0009 → result=0x0010, cout=0.
